// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and constants for the stream_demux_n block.
//               - state_t : packet-lock FSM state (IDLE / PKT)
//               - CNT_W   : width of the optional statistics counters
//               - clog2   : select-width helper, never returns less than 1
// Revision    : 1.0  initial release
// ============================================================================
package demux_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    localparam int CNT_W = 16;

    // Select width for a given channel count; a 1-bit select is the minimum
    // so that a 2-way (or degenerate) demux still has a legal port width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_out_slot
// Description : One-entry output register for a single demux channel.
//               A load always wins over a pop, so a full slot whose sink is
//               ready can accept a new beat in the same cycle it drains.
// Ports       : clk, rst_n       clock / asynchronous active-low reset
//               i_load           capture i_loadData / i_loadLast
//               i_loadData       beat payload
//               i_loadLast       beat last flag
//               i_ready          sink accepts the held beat
//               o_valid          slot holds a beat
//               o_data, o_last   held beat payload / last flag
// Revision    : 1.0  initial release
// ============================================================================
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_loadData,
    input  logic              i_loadLast,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_loadData;
            r_last  <= i_loadLast;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/stream_demux_n.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_n
// Description : NUM_OUT-way valid/ready stream demultiplexer with packet lock.
//               Each channel has a registered one-entry slot (1-cycle
//               latency, full throughput). The destination is sampled on the
//               first beat of a packet and held until the last beat. Beats
//               whose destination is >= NUM_OUT are accepted and dropped.
// Ports       : clock, reset_n   clock / asynchronous active-low reset
//               enable           0 blocks the source; slots keep draining
//               in_valid/in_ready/in_data/in_sel/in_last   source stream
//               out_valid/out_ready/out_data/out_last      per-channel sinks,
//                                channel k data at [k*DATA_W +: DATA_W]
//               locked           high while mid-packet
//               drop_pulse       one-cycle pulse per dropped beat
//               beat_cnt, drop_cnt  saturating statistics (optional)
// Options     : DEMUX_STATS_EN   adds beat_cnt / drop_cnt counters and ports
// Revision    : 1.0  initial release
// ============================================================================
module stream_demux_n #(
    parameter int NUM_OUT = 8,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = demux_pkg::clog2(NUM_OUT)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_last,
    output logic [NUM_OUT-1:0]          out_valid,
    input  logic [NUM_OUT-1:0]          out_ready,
    output logic [NUM_OUT*DATA_W-1:0]   out_data,
    output logic [NUM_OUT-1:0]          out_last,
    output logic                        locked,
    output logic                        drop_pulse
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_OUT*demux_pkg::CNT_W-1:0] beat_cnt,
    output logic [demux_pkg::CNT_W-1:0]         drop_cnt
`endif
);

    import demux_pkg::*;

    state_t             r_state;
    logic [SEL_W-1:0]   r_lockSel;
    logic               r_dropPulse;

    logic [SEL_W-1:0]   w_dest;
    logic [NUM_OUT-1:0] w_destOh;
    logic               w_bad;
    logic               w_accept;
    logic               w_acceptBad;
    logic [NUM_OUT-1:0] w_load;

    assign w_dest = (r_state == PKT) ? r_lockSel : in_sel;

    // One-hot decode of the destination; an all-zero vector means the code
    // is out of range, which avoids indexing past the last channel.
    always_comb begin
        w_destOh = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_destOh[k] = (w_dest == SEL_W'(k));
        end
    end

    assign w_bad       = ~|w_destOh;
    assign in_ready    = enable & (w_bad | (|(w_destOh & (~out_valid | out_ready))));
    assign w_accept    = in_valid & in_ready;
    assign w_acceptBad = w_accept & w_bad;
    assign w_load      = {NUM_OUT{w_accept & ~w_bad}} & w_destOh;

    // Packet-lock FSM. The lock select is captured even for an out-of-range
    // code so that the rest of that packet is dropped as well.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_lockSel   <= '0;
            r_dropPulse <= 1'b0;
        end else begin
            r_dropPulse <= w_acceptBad;
            case (r_state)
                IDLE: begin
                    if (w_accept && !in_last) begin
                        r_state   <= PKT;
                        r_lockSel <= in_sel;
                    end
                end
                PKT: begin
                    if (w_accept && in_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign locked     = (r_state == PKT);
    assign drop_pulse = r_dropPulse;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
        demux_out_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clock),
            .rst_n      (reset_n),
            .i_load     (w_load[k]),
            .i_loadData (in_data),
            .i_loadLast (in_last),
            .i_ready    (out_ready[k]),
            .o_valid    (out_valid[k]),
            .o_data     (out_data[k*DATA_W +: DATA_W]),
            .o_last     (out_last[k])
        );

`ifdef DEMUX_STATS_EN
        logic [CNT_W-1:0] r_beatCnt;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_beatCnt <= '0;
            end else if (w_load[k] && (r_beatCnt != '1)) begin
                r_beatCnt <= r_beatCnt + CNT_W'(1);
            end
        end

        assign beat_cnt[k*CNT_W +: CNT_W] = r_beatCnt;
`endif
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] r_dropCnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dropCnt <= '0;
        end else if (w_acceptBad && (r_dropCnt != '1)) begin
            r_dropCnt <= r_dropCnt + CNT_W'(1);
        end
    end

    assign drop_cnt = r_dropCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_n
// Description : Scoreboard bench for stream_demux_n. Stimulus pushes the
//               expected channel/data/last of each accepted beat; a monitor
//               pops and compares whenever a channel hands a beat to its sink.
//               A second 6-channel instance exercises out-of-range selects.
// Options     : DEMUX_STATS_EN   also checks the statistics counters
// Revision    : 1.0  initial release
// ============================================================================
module tb_stream_demux_n;

    localparam int NUM_OUT = 8;
    localparam int DATA_W  = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                      reset_n, enable, in_valid, in_last, in_ready;
    logic [DATA_W-1:0]         in_data;
    logic [2:0]                in_sel;
    logic [NUM_OUT-1:0]        out_valid, out_ready, out_last;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic                      locked, drop_pulse;

    logic                      enable6, inValid6, inLast6, inReady6;
    logic [DATA_W-1:0]         inData6;
    logic [2:0]                inSel6;
    logic [5:0]                outValid6, outReady6, outLast6;
    logic [6*DATA_W-1:0]       outData6;
    logic                      locked6, dropPulse6;

`ifdef DEMUX_STATS_EN
    logic [NUM_OUT*16-1:0]     beat_cnt;
    logic [15:0]               drop_cnt;
    logic [6*16-1:0]           beatCnt6;
    logic [15:0]               dropCnt6;
`endif

    stream_demux_n #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .locked(locked), .drop_pulse(drop_pulse)
`ifdef DEMUX_STATS_EN
        , .beat_cnt(beat_cnt), .drop_cnt(drop_cnt)
`endif
    );

    stream_demux_n #(.NUM_OUT(6), .DATA_W(DATA_W)) dut6 (
        .clock(clock), .reset_n(reset_n), .enable(enable6),
        .in_valid(inValid6), .in_ready(inReady6), .in_data(inData6),
        .in_sel(inSel6), .in_last(inLast6),
        .out_valid(outValid6), .out_ready(outReady6), .out_data(outData6),
        .out_last(outLast6), .locked(locked6), .drop_pulse(dropPulse6)
`ifdef DEMUX_STATS_EN
        , .beat_cnt(beatCnt6), .drop_cnt(dropCnt6)
`endif
    );

    typedef struct {
        int               ch;
        logic [DATA_W-1:0] data;
        logic             last;
        int               accCyc;
        bit               chkLat;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;
    int   cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: compares every beat a sink takes against the oldest pending
    // expectation for that channel.
    initial begin : monitor
        int idx;
        forever begin
            @(negedge clock);
            #2;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    idx = -1;
                    for (int i = 0; i < expQ.size(); i++) begin
                        if (expQ[i].ch == k) begin
                            idx = i;
                            break;
                        end
                    end
                    if (idx < 0) begin
                        nChecks++;
                        $display("FAIL unexpected beat ch%0d: got data %0h, expected none", k, out_data[k*DATA_W +: DATA_W]);
                    end else begin
                        check($sformatf("ch%0d data", k), out_data[k*DATA_W +: DATA_W], expQ[idx].data);
                        check($sformatf("ch%0d last", k), out_last[k], expQ[idx].last);
                        if (expQ[idx].chkLat) check($sformatf("ch%0d latency", k), cyc, expQ[idx].accCyc);
                        expQ.delete(idx);
                    end
                end
            end
        end
    end

    task automatic sendBeat(input int ch, input logic [2:0] sel, input logic [DATA_W-1:0] data,
                            input logic last, input bit chkLat, input string name);
        int waitCyc;
        @(negedge clock);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        waitCyc  = 0;
        #1;
        while (!in_ready && waitCyc < 50) begin
            @(negedge clock);
            #1;
            waitCyc++;
        end
        if (!in_ready) begin
            nChecks++;
            $display("FAIL %s accept timeout: in_ready 0, expected 1", name);
        end else begin
            expQ.push_back('{ch, data, last, cyc + 1, chkLat});
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0;
        out_ready = '1;
        enable6 = 1'b1; inValid6 = 1'b0; inData6 = '0; inSel6 = '0; inLast6 = 1'b0; outReady6 = '1;
        repeat (3) @(negedge clock);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        check("reset locked", locked, 0);
        check("reset drop_pulse", drop_pulse, 0);
        check("reset out_valid6", outValid6, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single beats to every channel.
        for (int s = 0; s < NUM_OUT; s++) begin
            sendBeat(s, 3'(s), 8'(8'hA0 + s), 1'b1, 1'b1, "t1");
            check("t1 locked", locked, 0);
        end

        // enable low blocks the source.
        @(negedge clock);
        enable = 1'b0; in_valid = 1'b1; in_sel = 3'd0; in_last = 1'b1;
        #1;
        check("enable0 in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0; enable = 1'b1;

        // Packet locked to ch3 while in_sel wanders.
        sendBeat(3, 3'd3, 8'h11, 1'b0, 1'b1, "t2b1");
        check("t2 locked b1", locked, 1);
        sendBeat(3, 3'd5, 8'h22, 1'b0, 1'b1, "t2b2");
        check("t2 locked b2", locked, 1);
        sendBeat(3, 3'd5, 8'h33, 1'b0, 1'b1, "t2b3");
        check("t2 locked b3", locked, 1);
        sendBeat(3, 3'd5, 8'h44, 1'b1, 1'b1, "t2b4");
        check("t2 locked b4", locked, 0);

        // Stalled ch2 does not block ch6; a second ch2 beat waits for it.
        @(negedge clock);
        out_ready[2] = 1'b0;
        sendBeat(2, 3'd2, 8'h5A, 1'b1, 1'b0, "t3a");
        sendBeat(6, 3'd6, 8'h66, 1'b1, 1'b1, "t3x");
        @(negedge clock);
        in_valid = 1'b1; in_sel = 3'd2; in_data = 8'hB2; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3 stall in_ready", in_ready, 0);
            check("t3 ch2 held", out_valid[2], 1);
            @(negedge clock);
        end
        out_ready[2] = 1'b1;
        #1;
        check("t3 release in_ready", in_ready, 1);
        expQ.push_back('{2, 8'hB2, 1'b1, cyc + 1, 1'b0});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        sendBeat(6, 3'd6, 8'h67, 1'b1, 1'b1, "t3y");

        // Out-of-range packet on the 6-channel instance: all beats dropped.
        for (int b = 0; b < 3; b++) begin
            @(negedge clock);
            inValid6 = 1'b1; inSel6 = (b == 0) ? 3'd7 : 3'd1; inData6 = 8'(8'h70 + b); inLast6 = (b == 2);
            #1;
            check("t4 in_ready6", inReady6, 1);
            @(posedge clock);
            #1;
            inValid6 = 1'b0;
            check("t4 drop_pulse6", dropPulse6, 1);
            check("t4 out_valid6", outValid6, 0);
            check("t4 locked6", locked6, (b < 2) ? 1'b1 : 1'b0);
        end
        @(negedge clock);
        inValid6 = 1'b1; inSel6 = 3'd1; inData6 = 8'h61; inLast6 = 1'b1;
        @(posedge clock);
        #1;
        inValid6 = 1'b0;
        check("t4 drop_pulse6 idle", dropPulse6, 0);
        check("t4 ch1 valid6", outValid6, 6'b000010);
        check("t4 ch1 data6", outData6[15:8], 8'h61);

        // Asynchronous reset in the middle of a packet.
        sendBeat(4, 3'd4, 8'hC1, 1'b0, 1'b0, "t5b1");
        check("t5 locked", locked, 1);
        @(negedge clock);
        in_valid = 1'b1; in_sel = 3'd4; in_data = 8'hC2; in_last = 1'b0;
        #1;
        reset_n = 1'b0;
        expQ.delete();
        #1;
        in_valid = 1'b0;
        check("t5 async out_valid", out_valid, 0);
        check("t5 async out_data", out_data, 0);
        check("t5 async out_last", out_last, 0);
        check("t5 async locked", locked, 0);
        check("t5 async drop_pulse", drop_pulse, 0);
        @(negedge clock);
        reset_n = 1'b1;
        sendBeat(1, 3'd1, 8'hD1, 1'b1, 1'b1, "t5b2");
        check("t5 locked after", locked, 0);

`ifdef DEMUX_STATS_EN
        begin
            int stalls;
            repeat (3) @(negedge clock);
            #1;
            check("t6 beat_cnt ch1", beat_cnt[31:16], 16'd1);
            check("t6 drop_cnt init", drop_cnt, 16'd0);
            check("t6 drop_cnt6 init", dropCnt6, 16'd0);
            stalls = 0;
            @(negedge clock);
            in_valid = 1'b1; in_sel = 3'd0; in_last = 1'b1;
            for (int i = 0; i < 70000; i++) begin
                in_data = 8'(i);
                #1;
                if (!in_ready) stalls++;
                else expQ.push_back('{0, 8'(i), 1'b1, cyc + 1, 1'b1});
                @(negedge clock);
            end
            in_valid = 1'b0;
            check("t6 bulk stalls", stalls, 0);
            @(negedge clock);
            #1;
            check("t6 beat_cnt ch0 saturated", beat_cnt[15:0], 16'hFFFF);
            inValid6 = 1'b1; inSel6 = 3'd6; inData6 = 8'h99; inLast6 = 1'b1;
            @(posedge clock);
            #1;
            inValid6 = 1'b0;
            check("t6 drop_cnt6", dropCnt6, 16'd1);
            check("t6 drop_cnt", drop_cnt, 16'd0);
        end
`endif

        repeat (5) @(negedge clock);
        #3;
        check("scoreboard drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
